// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: runs one single-word register read/write command at a time
// as a complete AXI4-Lite transaction and returns the response on a valid/ready port.
module axi_lite_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              axi_lite_aclk,
  input  logic              axi_lite_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_resp,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] axi_lite_awaddr,
  output logic              axi_lite_awvalid,
  input  logic              axi_lite_awready,
  output logic [DATA_W-1:0] axi_lite_wdata,
  output logic              axi_lite_wvalid,
  input  logic              axi_lite_wready,
  input  logic [1:0]        axi_lite_bresp,
  input  logic              axi_lite_bvalid,
  output logic              axi_lite_bready,
  output logic [ADDR_W-1:0] axi_lite_araddr,
  output logic              axi_lite_arvalid,
  input  logic              axi_lite_arready,
  input  logic [DATA_W-1:0] axi_lite_rdata,
  input  logic [1:0]        axi_lite_rresp,
  input  logic              axi_lite_rvalid,
  output logic              axi_lite_rready
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  // Every output lives in this register set, so next values are computed here
  // and nothing reaches a port combinationally.
  typedef struct packed {
    state_t            state;
    logic              cmd_ready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              rready;
    logic              rsp_valid;
    logic [1:0]        rsp_resp;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_write;
  } regs_t;
  regs_t r, r_d;
  logic aw_pending, w_pending;
  always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn)
    if (!axi_lite_aresetn) r <= '0;
    else r <= r_d;
  assign aw_pending = r.awvalid & ~axi_lite_awready;
  assign w_pending  = r.wvalid & ~axi_lite_wready;
  always_comb begin
    r_d = r;
    case (r.state)
      IDLE:
        if (cmd_valid & r.cmd_ready) begin
          r_d.cmd_ready = 1'b0;
          r_d.awaddr    = cmd_addr;
          r_d.araddr    = cmd_addr;
          r_d.wdata     = cmd_wdata;
          r_d.rsp_write = cmd_write;
          r_d.rsp_resp  = 2'b00;
          r_d.rsp_rdata = '0;
          if (cmd_addr[1:0] != 2'b00) begin
            r_d.state     = RSP;
            r_d.rsp_valid = 1'b1;
            r_d.rsp_resp  = 2'b10;
          end else if (cmd_write) begin
            r_d.state   = WR_AW_W;
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
          end else begin
            r_d.state   = RD_AR;
            r_d.arvalid = 1'b1;
          end
        end else r_d.cmd_ready = 1'b1;
      WR_AW_W: begin
        r_d.awvalid = aw_pending;
        r_d.wvalid  = w_pending;
        if (!aw_pending && !w_pending) begin
          r_d.state  = WR_B;
          r_d.bready = 1'b1;
        end
      end
      WR_B:
        if (axi_lite_bvalid) begin
          r_d.state     = RSP;
          r_d.bready    = 1'b0;
          r_d.rsp_valid = 1'b1;
          r_d.rsp_resp  = axi_lite_bresp;
          r_d.rsp_rdata = '0;
        end
      RD_AR:
        if (axi_lite_arready) begin
          r_d.state   = RD_R;
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
        end
      RD_R:
        if (axi_lite_rvalid) begin
          r_d.state     = RSP;
          r_d.rready    = 1'b0;
          r_d.rsp_valid = 1'b1;
          r_d.rsp_resp  = axi_lite_rresp;
          r_d.rsp_rdata = axi_lite_rdata;
        end
      RSP:
        if (rsp_ready) begin
          r_d.state     = IDLE;
          r_d.rsp_valid = 1'b0;
          r_d.cmd_ready = 1'b1;
        end
      default: r_d.state = IDLE;
    endcase
  end
  assign cmd_ready        = r.cmd_ready;
  assign rsp_valid        = r.rsp_valid;
  assign rsp_resp         = r.rsp_resp;
  assign rsp_rdata        = r.rsp_rdata;
  assign rsp_write        = r.rsp_write;
  assign axi_lite_awaddr  = r.awaddr;
  assign axi_lite_awvalid = r.awvalid;
  assign axi_lite_wdata   = r.wdata;
  assign axi_lite_wvalid  = r.wvalid;
  assign axi_lite_bready  = r.bready;
  assign axi_lite_araddr  = r.araddr;
  assign axi_lite_arvalid = r.arvalid;
  assign axi_lite_rready  = r.rready;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed steps against axi_lite_cmd_master with the
// slave side driven by hand and hand-computed expectations.
module tb_axi_lite_cmd_master;
  logic        clk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  int vectors = 0;
  int miscompares = 0;

  axi_lite_cmd_master dut (
    .axi_lite_aclk(clk), .axi_lite_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
    .axi_lite_awaddr(awaddr), .axi_lite_awvalid(awvalid), .axi_lite_awready(awready),
    .axi_lite_wdata(wdata), .axi_lite_wvalid(wvalid), .axi_lite_wready(wready),
    .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid), .axi_lite_bready(bready),
    .axi_lite_araddr(araddr), .axi_lite_arvalid(arvalid), .axi_lite_arready(arready),
    .axi_lite_rdata(rdata), .axi_lite_rresp(rresp), .axi_lite_rvalid(rvalid),
    .axi_lite_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cmd_ready"}, cmd_ready, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".rsp_resp"}, rsp_resp, 0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 0);
    chk({tag, ".rsp_write"}, rsp_write, 0);
    chk({tag, ".awaddr"}, awaddr, 0);
    chk({tag, ".awvalid"}, awvalid, 0);
    chk({tag, ".wdata"}, wdata, 0);
    chk({tag, ".wvalid"}, wvalid, 0);
    chk({tag, ".bready"}, bready, 0);
    chk({tag, ".araddr"}, araddr, 0);
    chk({tag, ".arvalid"}, arvalid, 0);
    chk({tag, ".rready"}, rready, 0);
  endtask

  task automatic slave_idle;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
  endtask

  initial begin
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    slave_idle();
    tick(); tick();
    chk_all_zero("reset");
    aresetn = 1;
    tick();
    chk("post_reset.cmd_ready", cmd_ready, 1);

    // write 0x4 <= DEADBEEF, slave always ready
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'hDEADBEEF;
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    chk("wr1.c1.awvalid", awvalid, 1);
    chk("wr1.c1.wvalid", wvalid, 1);
    chk("wr1.c1.awaddr", awaddr, 32'h4);
    chk("wr1.c1.wdata", wdata, 32'hDEADBEEF);
    chk("wr1.c1.cmd_ready", cmd_ready, 0);
    bvalid = 1; bresp = 2'b00;
    tick();
    chk("wr1.c2.awvalid", awvalid, 0);
    chk("wr1.c2.wvalid", wvalid, 0);
    chk("wr1.c2.bready", bready, 1);
    chk("wr1.c2.rsp_valid", rsp_valid, 0);
    tick();
    bvalid = 0;
    chk("wr1.c3.rsp_valid", rsp_valid, 1);
    chk("wr1.c3.rsp_resp", rsp_resp, 0);
    chk("wr1.c3.rsp_write", rsp_write, 1);
    chk("wr1.c3.rsp_rdata", rsp_rdata, 0);
    chk("wr1.c3.bready", bready, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("wr1.c4.rsp_valid", rsp_valid, 0);
    chk("wr1.c4.cmd_ready", cmd_ready, 1);

    // write 0x8, wready immediately, awready only in cycle 4
    slave_idle();
    wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'h12345678;
    tick();
    cmd_valid = 0;
    chk("wr2.c1.awvalid", awvalid, 1);
    chk("wr2.c1.wvalid", wvalid, 1);
    tick();
    chk("wr2.c2.wvalid", wvalid, 0);
    chk("wr2.c2.awvalid", awvalid, 1);
    chk("wr2.c2.awaddr", awaddr, 32'h8);
    tick();
    chk("wr2.c3.awvalid", awvalid, 1);
    chk("wr2.c3.bready", bready, 0);
    tick();
    awready = 1;
    chk("wr2.c4.awvalid", awvalid, 1);
    chk("wr2.c4.awaddr", awaddr, 32'h8);
    tick();
    awready = 0;
    chk("wr2.c5.awvalid", awvalid, 0);
    chk("wr2.c5.bready", bready, 1);
    bvalid = 1;
    tick();
    bvalid = 0;
    chk("wr2.c6.rsp_valid", rsp_valid, 1);
    chk("wr2.c6.rsp_write", rsp_write, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // read 0x4, rvalid held off for three RD_R cycles, rresp OKAY-variant
    slave_idle();
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4;
    tick();
    cmd_valid = 0;
    chk("rd1.c1.arvalid", arvalid, 1);
    chk("rd1.c1.araddr", araddr, 32'h4);
    chk("rd1.c1.awvalid", awvalid, 0);
    tick();
    chk("rd1.c2.arvalid", arvalid, 0);
    chk("rd1.c2.rready", rready, 1);
    tick();
    tick();
    chk("rd1.c4.rready", rready, 1);
    chk("rd1.c4.rsp_valid", rsp_valid, 0);
    tick();
    rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b01;
    tick();
    rvalid = 0;
    chk("rd1.rsp_valid", rsp_valid, 1);
    chk("rd1.rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd1.rsp_resp", rsp_resp, 2'b01);
    chk("rd1.rsp_write", rsp_write, 0);
    chk("rd1.rready", rready, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // read 0x40 with SLVERR, response held off 5 cycles while an unaligned write waits
    slave_idle();
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
    tick();
    cmd_valid = 0;
    chk("rd2.c1.arvalid", arvalid, 1);
    rvalid = 1; rdata = 32'hCAFE0001; rresp = 2'b10;
    tick();
    chk("rd2.c2.rready", rready, 1);
    tick();
    rvalid = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h6; cmd_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d.rsp_valid", i), rsp_valid, 1);
      chk($sformatf("hold%0d.rsp_rdata", i), rsp_rdata, 32'hCAFE0001);
      chk($sformatf("hold%0d.rsp_resp", i), rsp_resp, 2'b10);
      chk($sformatf("hold%0d.cmd_ready", i), cmd_ready, 0);
      tick();
    end
    rsp_ready = 1;
    chk("rd2.release.rsp_valid", rsp_valid, 1);
    tick();
    rsp_ready = 0;
    chk("una.c0.rsp_valid", rsp_valid, 0);
    chk("una.c0.cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("una.c1.rsp_valid", rsp_valid, 1);
    chk("una.c1.rsp_resp", rsp_resp, 2'b10);
    chk("una.c1.rsp_rdata", rsp_rdata, 0);
    chk("una.c1.rsp_write", rsp_write, 1);
    chk("una.c1.awvalid", awvalid, 0);
    chk("una.c1.wvalid", wvalid, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("una.c2.awvalid", awvalid, 0);
    chk("una.c2.cmd_ready", cmd_ready, 1);

    // async reset while awvalid is high
    slave_idle();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hC; cmd_wdata = 32'hA5A5A5A5;
    tick();
    cmd_valid = 0;
    chk("rst.c1.awvalid", awvalid, 1);
    #2 aresetn = 0;
    #1;
    chk_all_zero("midrst");
    slave_idle();
    tick();
    aresetn = 1;
    tick();
    chk("rst.after.cmd_ready", cmd_ready, 1);
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0;
    tick();
    cmd_valid = 0;
    chk("rd3.c1.arvalid", arvalid, 1);
    chk("rd3.c1.araddr", araddr, 32'h0);
    rvalid = 1; rdata = 32'h0A0B0C0D; rresp = 2'b00;
    tick();
    chk("rd3.c2.rready", rready, 1);
    tick();
    rvalid = 0;
    chk("rd3.rsp_valid", rsp_valid, 1);
    chk("rd3.rsp_rdata", rsp_rdata, 32'h0A0B0C0D);
    chk("rd3.rsp_resp", rsp_resp, 2'b00);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rd3.done.cmd_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
